// File: rtl/test_regs_reg_pkg.sv
// Types, offsets and write-permission masks shared by the test_regs register block.
`default_nettype none
package test_regs_reg_pkg;

  localparam int BlockAw = 4;

  localparam logic [BlockAw-1:0] TEST_REGS_REG0_OFFSET   = 4'h0;
  localparam logic [BlockAw-1:0] TEST_REGS_REG1_OFFSET   = 4'h4;
  localparam logic [BlockAw-1:0] TEST_REGS_STATUS_OFFSET = 4'h8;
  localparam logic [BlockAw-1:0] TEST_REGS_CTRL_OFFSET   = 4'hC;

  // Byte lanes a write must cover, indexed by word offset (addr[3:2]).
  localparam logic [3:0] TEST_REGS_PERMIT [4] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111};

  typedef enum logic [0:0] {
    SwRW  = 1'b0,
    SwW1C = 1'b1
  } sw_access_e;

  typedef struct packed {
    logic               valid;
    logic               write;
    logic [BlockAw-1:0] addr;
    logic [31:0]        wdata;
    logic [3:0]         wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;

  typedef struct packed {
    struct packed { logic [31:0] q; logic qe; } reg0;
    struct packed { logic [31:0] q; }           reg1;
    struct packed { logic q; }                  ctrl_en;
    struct packed { logic q; }                  ctrl_done;
  } reg2hw_t;

  typedef struct packed {
    struct packed { logic [31:0] d; logic de; } reg1;
    struct packed { logic [31:0] d; }           status;
    struct packed { logic d; logic de; }        ctrl_done;
  } hw2reg_t;

endpackage
`default_nettype wire

// File: rtl/test_regs_subreg.sv
// One stored register field: software RW (software beats hardware) or W1C (hardware set beats clear).
`default_nettype none
module test_regs_subreg
  import test_regs_reg_pkg::*;
#(
  parameter int            DW       = 32,
  parameter sw_access_e    SWACCESS = SwRW,
  parameter logic [DW-1:0] RESVAL   = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          i_we,
  input  logic [DW-1:0] i_wd,
  input  logic          i_de,
  input  logic [DW-1:0] i_d,
  output logic          o_qe,
  output logic [DW-1:0] o_q
);

  logic [DW-1:0] r_q;
  logic          r_qe;
  logic [DW-1:0] w_next;

  if (SwRW == SWACCESS) begin : g_rw
    assign w_next = i_we ? i_wd : (i_de ? i_d : r_q);
  end else begin : g_w1c
    assign w_next = (r_q & ~(i_we ? i_wd : '0)) | (i_de ? i_d : '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q  <= RESVAL;
      r_qe <= 1'b0;
    end else begin
      r_q  <= w_next;
      r_qe <= i_we;
    end
  end

  assign o_q  = r_q;
  assign o_qe = r_qe;

endmodule
`default_nettype wire

// File: rtl/test_regs_reg_top.sv
// test_regs register block: address decode, error generation and zero-wait-state read mux.
`default_nettype none
module test_regs_reg_top
  import test_regs_reg_pkg::*;
#(
  parameter type reg_req_t = test_regs_reg_pkg::reg_req_t,
  parameter type reg_rsp_t = test_regs_reg_pkg::reg_rsp_t,
  parameter int  AW        = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  reg_req_t reg_req_i,
  output reg_rsp_t reg_rsp_o,
  output reg2hw_t  reg2hw,
  input  hw2reg_t  hw2reg,
  input  logic     devmode_i
);

  if (AW < 4) begin : g_aw_check
    $error("AW must be at least 4");
  end

  logic [3:0]  w_addr;
  logic        w_hit_reg0, w_hit_reg1, w_hit_status, w_hit_ctrl, w_mapped;
  logic        w_perm_err, w_err;
  logic        w_wr_ok;
  logic        w_we_reg0, w_we_reg1, w_we_ctrl;
  logic [31:0] w_rdata;
  logic        w_unused_qe;

  assign w_addr       = reg_req_i.addr[3:0];
  assign w_hit_reg0   = (w_addr == TEST_REGS_REG0_OFFSET);
  assign w_hit_reg1   = (w_addr == TEST_REGS_REG1_OFFSET);
  assign w_hit_status = (w_addr == TEST_REGS_STATUS_OFFSET);
  assign w_hit_ctrl   = (w_addr == TEST_REGS_CTRL_OFFSET);
  assign w_mapped     = w_hit_reg0 | w_hit_reg1 | w_hit_status | w_hit_ctrl;

  // STATUS silently drops writes, so partial strobes there are not an error.
  assign w_perm_err = reg_req_i.write & w_mapped & ~w_hit_status &
                      ((TEST_REGS_PERMIT[w_addr[3:2]] & ~reg_req_i.wstrb) != 4'b0000);
  assign w_err      = reg_req_i.valid & ((~w_mapped & devmode_i) | w_perm_err);

  assign w_wr_ok   = reg_req_i.valid & reg_req_i.write & ~w_err;
  assign w_we_reg0 = w_wr_ok & w_hit_reg0;
  assign w_we_reg1 = w_wr_ok & w_hit_reg1;
  assign w_we_ctrl = w_wr_ok & w_hit_ctrl;

  test_regs_subreg #(.DW(32), .SWACCESS(SwRW), .RESVAL(32'h0)) u_reg0 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_we   (w_we_reg0),
    .i_wd   (reg_req_i.wdata),
    .i_de   (1'b0),
    .i_d    (32'h0),
    .o_qe   (reg2hw.reg0.qe),
    .o_q    (reg2hw.reg0.q)
  );

  logic w_qe_reg1, w_qe_en, w_qe_done;

  test_regs_subreg #(.DW(32), .SWACCESS(SwRW), .RESVAL(32'h0)) u_reg1 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_we   (w_we_reg1),
    .i_wd   (reg_req_i.wdata),
    .i_de   (hw2reg.reg1.de),
    .i_d    (hw2reg.reg1.d),
    .o_qe   (w_qe_reg1),
    .o_q    (reg2hw.reg1.q)
  );

  test_regs_subreg #(.DW(1), .SWACCESS(SwRW), .RESVAL(1'b0)) u_ctrl_en (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_we   (w_we_ctrl),
    .i_wd   (reg_req_i.wdata[0]),
    .i_de   (1'b0),
    .i_d    (1'b0),
    .o_qe   (w_qe_en),
    .o_q    (reg2hw.ctrl_en.q)
  );

  test_regs_subreg #(.DW(1), .SWACCESS(SwW1C), .RESVAL(1'b0)) u_ctrl_done (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_we   (w_we_ctrl),
    .i_wd   (reg_req_i.wdata[1]),
    .i_de   (hw2reg.ctrl_done.de),
    .i_d    (hw2reg.ctrl_done.d),
    .o_qe   (w_qe_done),
    .o_q    (reg2hw.ctrl_done.q)
  );

  assign w_unused_qe = w_qe_reg1 ^ w_qe_en ^ w_qe_done;

  always_comb begin
    w_rdata = 32'h0;
    if (reg_req_i.valid && !reg_req_i.write && !w_err) begin
      case (w_addr)
        TEST_REGS_REG0_OFFSET:   w_rdata = reg2hw.reg0.q;
        TEST_REGS_REG1_OFFSET:   w_rdata = reg2hw.reg1.q;
        TEST_REGS_STATUS_OFFSET: w_rdata = hw2reg.status.d;
        TEST_REGS_CTRL_OFFSET:   w_rdata = {30'h0, reg2hw.ctrl_done.q, reg2hw.ctrl_en.q};
        default:                 w_rdata = 32'h0;
      endcase
    end
  end

  assign reg_rsp_o.ready = 1'b1;
  assign reg_rsp_o.rdata = w_rdata;
  assign reg_rsp_o.error = w_err;

endmodule
`default_nettype wire

// File: tb/tb_test_regs_reg_top.sv
// Scoreboard bench for test_regs_reg_top: expected responses queued at drive time, popped at sample time.
`default_nettype none
module tb_test_regs_reg_top;
  import test_regs_reg_pkg::*;

  logic     clk_i;
  logic     rst_ni;
  reg_req_t reg_req_i;
  reg_rsp_t reg_rsp_o;
  reg2hw_t  reg2hw;
  hw2reg_t  hw2reg;
  logic     devmode_i;

  int total = 0;
  int bad   = 0;
  logic [32:0] sb_q[$];

  test_regs_reg_top #(.AW(4)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .reg_req_i (reg_req_i),
    .reg_rsp_o (reg_rsp_o),
    .reg2hw    (reg2hw),
    .hw2reg    (hw2reg),
    .devmode_i (devmode_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One bus transfer: drive at negedge, compare the combinational response, commit at posedge.
  task automatic access(input string tag, input logic wr, input logic [3:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic exp_err, input logic [31:0] exp_rdata);
    logic [32:0] e;
    @(negedge clk_i);
    reg_req_i.valid = 1'b1;
    reg_req_i.write = wr;
    reg_req_i.addr  = addr;
    reg_req_i.wdata = wdata;
    reg_req_i.wstrb = wstrb;
    sb_q.push_back({exp_err, exp_rdata});
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_err"}, 64'(reg_rsp_o.error), 64'(e[32]));
      chk({tag, "_rdata"}, 64'(reg_rsp_o.rdata), 64'(e[31:0]));
      chk({tag, "_ready"}, 64'(reg_rsp_o.ready), 64'd1);
    end
    @(posedge clk_i);
    #1;
    reg_req_i = '0;
  endtask

  task automatic hw_pulse_done();
    @(negedge clk_i);
    hw2reg.ctrl_done.de = 1'b1;
    hw2reg.ctrl_done.d  = 1'b1;
    @(posedge clk_i);
    #1;
    hw2reg.ctrl_done = '0;
  endtask

  initial begin
    rst_ni    = 1'b0;
    reg_req_i = '0;
    hw2reg    = '0;
    devmode_i = 1'b1;
    hw2reg.status.d = 32'hCAFEF00D;
    repeat (2) @(posedge clk_i);

    // Reset-time behaviour: outputs zero, bus still answers combinationally.
    #1;
    chk("rst_reg2hw", 64'(reg2hw), 64'd0);
    access("rst_rd_reg0", 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    access("rst_rd_status", 1'b0, 4'h8, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D);
    access("rst_wr_reg0", 1'b1, 4'h0, 32'h1111_1111, 4'hF, 1'b0, 32'h0);
    chk("rst_wr_discard", 64'(reg2hw.reg0.q), 64'd0);

    @(negedge clk_i);
    rst_ni = 1'b1;

    access("wr_reg0", 1'b1, 4'h0, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    chk("reg0_qe_pulse", 64'(reg2hw.reg0.qe), 64'd1);
    access("rd_reg0", 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);
    chk("reg0_qe_drop", 64'(reg2hw.reg0.qe), 64'd0);
    chk("reg2hw_reg0", 64'(reg2hw.reg0.q), 64'hDEADBEEF);

    access("wr_partial", 1'b1, 4'h0, 32'h12345678, 4'h3, 1'b1, 32'h0);
    chk("partial_no_qe", 64'(reg2hw.reg0.qe), 64'd0);
    access("rd_after_partial", 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);

    // Unmapped and misaligned addresses, with and without devmode.
    access("rd_unmapped_dev", 1'b0, 4'h1, 32'h0, 4'h0, 1'b1, 32'h0);
    access("wr_unmapped_dev", 1'b1, 4'h6, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0);
    devmode_i = 1'b0;
    access("rd_unmapped_nodev", 1'b0, 4'h1, 32'h0, 4'h0, 1'b0, 32'h0);
    access("wr_unmapped_nodev", 1'b1, 4'h2, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0);
    access("rd_reg0_intact", 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);
    devmode_i = 1'b1;

    // REG1: hardware update alone, then software beating hardware.
    hw2reg.reg1.de = 1'b1;
    hw2reg.reg1.d  = 32'h5A5A_0001;
    @(posedge clk_i);
    #1;
    hw2reg.reg1 = '0;
    access("rd_reg1_hw", 1'b0, 4'h4, 32'h0, 4'h0, 1'b0, 32'h5A5A_0001);
    hw2reg.reg1.de = 1'b1;
    hw2reg.reg1.d  = 32'hA5A5A5A5;
    access("wr_reg1_race", 1'b1, 4'h4, 32'h1, 4'hF, 1'b0, 32'h0);
    hw2reg.reg1 = '0;
    access("rd_reg1_sw_wins", 1'b0, 4'h4, 32'h0, 4'h0, 1'b0, 32'h1);
    chk("reg2hw_reg1", 64'(reg2hw.reg1.q), 64'h1);

    // STATUS is read-only and ignores writes.
    hw2reg.status.d = 32'h0BAD_F00D;
    access("wr_status", 1'b1, 4'h8, 32'hFFFF_FFFF, 4'h1, 1'b0, 32'h0);
    access("rd_status", 1'b0, 4'h8, 32'h0, 4'h0, 1'b0, 32'h0BAD_F00D);

    // CTRL: DONE set by hardware, cleared by W1C, set wins over clear.
    hw_pulse_done();
    access("rd_ctrl_done", 1'b0, 4'hC, 32'h0, 4'h0, 1'b0, 32'h2);
    chk("reg2hw_done", 64'(reg2hw.ctrl_done.q), 64'd1);
    access("wr_ctrl_clr", 1'b1, 4'hC, 32'h2, 4'hF, 1'b0, 32'h0);
    access("rd_ctrl_clr", 1'b0, 4'hC, 32'h0, 4'h0, 1'b0, 32'h0);
    hw2reg.ctrl_done.de = 1'b1;
    hw2reg.ctrl_done.d  = 1'b1;
    access("wr_ctrl_race", 1'b1, 4'hC, 32'h2, 4'hF, 1'b0, 32'h0);
    hw2reg.ctrl_done = '0;
    access("rd_ctrl_set_wins", 1'b0, 4'hC, 32'h0, 4'h0, 1'b0, 32'h2);
    access("wr_ctrl_en", 1'b1, 4'hC, 32'hFFFF_FFFD, 4'hF, 1'b0, 32'h0);
    access("rd_ctrl_en", 1'b0, 4'hC, 32'h0, 4'h0, 1'b0, 32'h3);
    chk("reg2hw_en", 64'(reg2hw.ctrl_en.q), 64'd1);

    // Asynchronous reset mid-cycle with a read of REG0 in flight.
    access("wr_reg0_again", 1'b1, 4'h0, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    @(negedge clk_i);
    reg_req_i.valid = 1'b1;
    reg_req_i.addr  = 4'h0;
    #2;
    chk("pre_async_rd", 64'(reg_rsp_o.rdata), 64'hDEADBEEF);
    rst_ni = 1'b0;
    #1;
    chk("async_rd_reg0", 64'(reg_rsp_o.rdata), 64'd0);
    chk("async_reg2hw", 64'(reg2hw), 64'd0);
    reg_req_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    if (sb_q.size() != 0) chk("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
